// File: rtl/jac_alu_pkg.sv
// Shared constants, instruction field positions and FSM state type for the
// ALU_J execute-stage controller.
package jac_alu_pkg;

  localparam int DataWidth     = 8;
  localparam int NumRegs       = 8;
  localparam int RegAddrBits   = 3;
  localparam int NumOpCodeBits = 5;
  localparam int ParamBits     = 8;
  localparam int NumStatusBits = 6;
  localparam int InstrWidth    = 24;

  localparam logic [NumOpCodeBits-1:0] Op_NOP = 5'd0;
  localparam logic [NumOpCodeBits-1:0] Op_ADD = 5'd1;
  localparam logic [NumOpCodeBits-1:0] Op_SUB = 5'd2;
  localparam logic [NumOpCodeBits-1:0] Op_AND = 5'd3;
  localparam logic [NumOpCodeBits-1:0] Op_OR  = 5'd4;
  localparam logic [NumOpCodeBits-1:0] Op_NOT = 5'd5;
  localparam logic [NumOpCodeBits-1:0] Op_XOR = 5'd6;
  localparam logic [NumOpCodeBits-1:0] Op_SHL = 5'd7;
  localparam logic [NumOpCodeBits-1:0] Op_SHR = 5'd8;
  localparam logic [NumOpCodeBits-1:0] Op_VAL = 5'd9;
  localparam logic [NumOpCodeBits-1:0] Op_CMP = 5'd10;

  localparam int CarryBit       = 0;
  localparam int UnderflowBit   = 1;
  localparam int ZeroBit        = 2;
  localparam int EqualBit       = 3;
  localparam int GreaterThanBit = 4;
  localparam int SmallerThanBit = 5;

  localparam int OpLsb    = 19;
  localparam int RdLsb    = 16;
  localparam int RaLsb    = 13;
  localparam int RbLsb    = 10;
  localparam int RsvLsb   = 8;
  localparam int ParamLsb = 0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_WRITE   = 2'd3
  } state_e;

  // ADD..VAL write the destination register; CMP only updates status.
  function automatic logic op_writes_rf(input logic [NumOpCodeBits-1:0] op);
    return (op >= Op_ADD) && (op <= Op_VAL);
  endfunction

  function automatic logic op_reserved(input logic [NumOpCodeBits-1:0] op);
    return op > Op_CMP;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake, ALU_J bus and debug signals of alu_exec_ctrl.
// Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready.
interface alu_exec_ctrl_if;
  import jac_alu_pkg::*;

  logic                     instr_valid;
  logic                     instr_ready;
  logic [InstrWidth-1:0]    instr;
  logic [NumOpCodeBits-1:0] alu_opcode;
  logic [DataWidth-1:0]     alu_operand1;
  logic [DataWidth-1:0]     alu_operand2;
  logic [ParamBits-1:0]     alu_param;
  logic [DataWidth-1:0]     alu_result;
  logic [NumStatusBits-1:0] alu_status;
  logic [NumStatusBits-1:0] status_q;
  logic                     done;
  logic [RegAddrBits-1:0]   dbg_addr;
  logic [DataWidth-1:0]     dbg_data;
  state_e                   dbg_state;
`ifdef JAC_ILLEGAL_OP_TRAP_EN
  logic                     illegal_op;
`endif

  modport slave (
    input  instr_valid, instr, alu_result, alu_status, dbg_addr,
    output instr_ready, alu_opcode, alu_operand1, alu_operand2, alu_param,
    output status_q, done, dbg_data, dbg_state
`ifdef JAC_ILLEGAL_OP_TRAP_EN
    , output illegal_op
`endif
  );

  modport master (
    output instr_valid, instr, alu_result, alu_status, dbg_addr,
    input  instr_ready, alu_opcode, alu_operand1, alu_operand2, alu_param,
    input  status_q, done, dbg_data, dbg_state
`ifdef JAC_ILLEGAL_OP_TRAP_EN
    , input illegal_op
`endif
  );

endinterface

// File: rtl/jac_regfile.sv
// 8x8 register file: two operand read ports, one debug read port, one
// synchronous write port; r0 always reads zero and ignores writes.
module jac_regfile
  import jac_alu_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   we_i,
  input  logic [RegAddrBits-1:0] waddr_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [RegAddrBits-1:0] raddr_a_i,
  input  logic [RegAddrBits-1:0] raddr_b_i,
  input  logic [RegAddrBits-1:0] dbg_addr_i,
  output logic [DataWidth-1:0]   rdata_a_o,
  output logic [DataWidth-1:0]   rdata_b_o,
  output logic [DataWidth-1:0]   dbg_data_o
);

  logic [DataWidth-1:0] rf_q [NumRegs];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumRegs; i++) rf_q[i] <= '0;
    end else if (we_i && (waddr_i != '0)) begin
      rf_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o  = (raddr_a_i  == '0) ? '0 : rf_q[raddr_a_i];
  assign rdata_b_o  = (raddr_b_i  == '0) ? '0 : rf_q[raddr_b_i];
  assign dbg_data_o = (dbg_addr_i == '0) ? '0 : rf_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Non-pipelined execute-stage controller around ALU_J: IDLE->ISSUE->CAPTURE->WRITE.
// Optional macro JAC_ILLEGAL_OP_TRAP_EN adds a sticky illegal_op flag.
module alu_exec_ctrl
  import jac_alu_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  alu_exec_ctrl_if.slave bus
);

  state_e                   state_q, state_d;
  logic [NumOpCodeBits-1:0] op_q;
  logic [RegAddrBits-1:0]   rd_q, ra_q, rb_q;
  logic [ParamBits-1:0]     prm_q;
  logic [NumOpCodeBits-1:0] alu_opcode_q;
  logic [DataWidth-1:0]     alu_op1_q, alu_op2_q;
  logic [ParamBits-1:0]     alu_param_q;
  logic [DataWidth-1:0]     res_q, rdata_a, rdata_b;
  logic [NumStatusBits-1:0] stat_q, arch_status_q;
  logic                     rf_we, instr_ready, done;
  logic                     unused_reserved;

  assign unused_reserved = ^bus.instr[RsvLsb +: 2];
  assign rf_we = (state_q == ST_WRITE) && op_writes_rf(op_q);

  jac_regfile u_regfile (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rd_q),
    .wdata_i    (res_q),
    .raddr_a_i  (ra_q),
    .raddr_b_i  (rb_q),
    .dbg_addr_i (bus.dbg_addr),
    .rdata_a_o  (rdata_a),
    .rdata_b_o  (rdata_b),
    .dbg_data_o (bus.dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) state_d = ST_ISSUE;
      end
      ST_ISSUE:   state_d = ST_CAPTURE;
      ST_CAPTURE: state_d = ST_WRITE;
      ST_WRITE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q          <= Op_NOP;
      rd_q          <= '0;
      ra_q          <= '0;
      rb_q          <= '0;
      prm_q         <= '0;
      alu_opcode_q  <= Op_NOP;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_param_q   <= '0;
      res_q         <= '0;
      stat_q        <= '0;
      arch_status_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.instr_valid) begin
          op_q  <= bus.instr[OpLsb    +: NumOpCodeBits];
          rd_q  <= bus.instr[RdLsb    +: RegAddrBits];
          ra_q  <= bus.instr[RaLsb    +: RegAddrBits];
          rb_q  <= bus.instr[RbLsb    +: RegAddrBits];
          prm_q <= bus.instr[ParamLsb +: ParamBits];
        end
        ST_ISSUE: begin
          alu_opcode_q <= op_q;
          alu_op1_q    <= rdata_a;
          alu_op2_q    <= rdata_b;
          alu_param_q  <= prm_q;
        end
        ST_CAPTURE: begin
          res_q  <= bus.alu_result;
          stat_q <= bus.alu_status;
        end
        ST_WRITE: begin
          // Reserved opcodes fall through here as NOP: no rf write, no status update.
          if (op_writes_rf(op_q) || (op_q == Op_CMP)) arch_status_q <= stat_q;
          alu_opcode_q <= Op_NOP;
          alu_op1_q    <= '0;
          alu_op2_q    <= '0;
          alu_param_q  <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef JAC_ILLEGAL_OP_TRAP_EN
  logic illegal_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          illegal_q <= 1'b0;
    else if ((state_q == ST_WRITE) && op_reserved(op_q)) illegal_q <= 1'b1;
  end

  assign bus.illegal_op = illegal_q;
`endif

  assign bus.instr_ready  = instr_ready;
  assign bus.done         = done;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_operand1 = alu_op1_q;
  assign bus.alu_operand2 = alu_op2_q;
  assign bus.alu_param    = alu_param_q;
  assign bus.status_q     = arch_status_q;
  assign bus.dbg_state    = state_q;

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute-stage controller directly around ALU_J in the 8-bit core.
- Accepts one decoded instruction word per valid/ready handshake and reads two source registers from an internal 8x8 register file.
- Drives ALU_J opcode/operand1/operand2/param, captures result and status, writes the destination register, and updates the architectural status register.
- Multi-cycle and non-pipelined: one instruction in flight.

Parameters:
- DataWidth, 8, register/operand width
- NumRegs, 8, register file depth
- RegAddrBits, 3, register index width
- NumOpCodeBits, 5, ALU opcode width
- ParamBits, 8, ALU param width
- NumStatusBits, 6, ALU status width
- InstrWidth, 24, instruction word width

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  controller can accept
- instr  in  InstrWidth  [23:19] opcode, [18:16] rd, [15:13] ra, [12:10] rb, [9:8] reserved (ignored), [7:0] param
- alu_opcode  out  NumOpCodeBits  to ALU_J opcode
- alu_operand1  out  DataWidth  to ALU_J operand1
- alu_operand2  out  DataWidth  to ALU_J operand2
- alu_param  out  ParamBits  to ALU_J param
- alu_result  in  DataWidth  from ALU_J result
- alu_status  in  NumStatusBits  from ALU_J status (bit0 Carry, 1 Underflow, 2 Zero, 3 Equal, 4 GreaterThan, 5 SmallerThan)
- status_q  out  NumStatusBits  architectural status register
- done  out  1  high for exactly the WRITE cycle
- dbg_addr  in  RegAddrBits  debug read index
- dbg_data  out  DataWidth  combinational read of rf[dbg_addr]

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all registers 0; status_q=0; alu_opcode=NOP (5'b00000); alu_operand1/2=0; alu_param=0; done=0; instr_ready=1 once out of reset.
- FSM IDLE -> ISSUE -> CAPTURE -> WRITE -> IDLE.
- IDLE:
  - instr_ready=1.
  - On edge with instr_valid&&instr_ready (E0): latch instr, go ISSUE.
- ISSUE:
  - rf[ra], rf[rb] and latched opcode/param loaded into alu_* output registers at edge E1.
  - Go CAPTURE.
- CAPTURE:
  - ALU_J settles combinationally.
  - At edge E2, alu_result and alu_status are registered into res_q and stat_q.
  - Go WRITE.
- WRITE:
  - done=1.
  - At edge E3: commit per opcode, clear alu_* to NOP/0, go IDLE.
- Latency and throughput:
  - instr_ready low for exactly 3 cycles per instruction; throughput 1 per 4 cycles.
  - An instruction held on instr_valid is accepted only in IDLE.
- Commit rules:
  - NOP: no rf write, status_q unchanged.
  - CMP (5'b01010): status_q<=stat_q, no rf write.
  - ADD/SUB/AND/OR/NOT/XOR/SHL/SHR/VAL: rf[rd]<=res_q, status_q<=stat_q.
  - Reserved opcodes 5'b01011..5'b11111: treated as NOP.
- r0 is hardwired zero:
  - Reads (operand and debug) return 0.
  - Writes are dropped; the status update still occurs.
- Operand mapping: operand1=rf[ra], operand2=rf[rb]; ra==rb is legal. NOT result is defined by ALU_J; no special handling here.
- Debug read reflects committed contents only; a write at E3 is visible from the following cycle.
- Reset mid-operation: abort immediately, no rf or status write, all state to reset values.

Optional Feature:
- JAC_ILLEGAL_OP_TRAP_EN defined:
  - Adds output port illegal_op (1 bit).
  - A reserved opcode sets illegal_op at E3 (sticky, cleared only by reset).
  - The reserved-op instruction still behaves as NOP.
- Undefined: port absent; reserved opcodes silently NOP.

Decomposition:
- Package jac_alu_pkg:
  - Opcode constants Op_NOP..Op_CMP.
  - Status bit indices (CarryBit..SmallerThanBit).
  - Width constants.
  - Instruction field positions.
  - FSM state enum typedef.
- Sub-module jac_regfile: NumRegs x DataWidth, two operand read ports plus one debug read port, one synchronous write port, async reset clears all entries, r0 reads 0 and ignores writes.

Test Plan:
- Reset with rst_n=0 -> instr_ready=1, status_q=0, alu_opcode=0, dbg_data=0 for all dbg_addr 0..7.
- VAL r1 param 0xFF; VAL r2 param 0x02; ADD rd=3 ra=1 rb=2 -> dbg r3=0x01, status_q[Carry]=1, status_q[GreaterThan]=1, done high exactly in the 3rd cycle after acceptance.
- r5=0x0E, r6=0x0F; SUB rd=4 ra=5 rb=6 -> r4=0xFF, status_q[1:0]=2'b10, status_q[SmallerThan]=1.
- r1=0xF6, r3=0x11; CMP rd=3 ra=1 rb=1 -> r3 still 0x11, status_q=6'b001000.
- VAL rd=0 param 0x55 -> dbg r0=0x00; then NOP -> status_q unchanged; opcode 5'b11111 -> no write (illegal_op=1 when JAC_ILLEGAL_OP_TRAP_EN).
- instr_valid held high with ADD then SUB -> second accepted 4 cycles after first; rst_n pulsed low during CAPTURE -> target register and status_q remain 0, FSM in IDLE.
